// File: rtl/muller_c_sched.sv
// Round-robin scheduler that time-shares one Muller C-element among NREQ four-phase requesters.
// The C-element output is asynchronous and is brought in through a 2-flop synchronizer.
module muller_c_sched #(
    parameter int NREQ    = 4,
    parameter int SETTLE  = 3,
    parameter int TIMEOUT = 15
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic [NREQ-1:0] req_i,
    input  logic [NREQ-1:0] op_a_i,
    input  logic [NREQ-1:0] op_b_i,
    output logic [NREQ-1:0] ack_o,
    output logic [NREQ-1:0] res_o,
    output logic            cel_a_o,
    output logic            cel_b_o,
    output logic            cel_rst_o,
    input  logic            cel_c_i,
    output logic [2:0]      grant_o,
    output logic            busy_o,
    output logic            err_o,
    output logic [2:0]      dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARB     = 3'd1,
        S_DRIVE   = 3'd2,
        S_WAIT    = 3'd3,
        S_ACK     = 3'd4,
        S_RELEASE = 3'd5
    } state_t;

    localparam logic [7:0] L_SETTLE  = 8'(SETTLE);
    localparam logic [7:0] L_TIMEOUT = 8'(TIMEOUT);

    state_t          r_state;
    state_t          w_nxt;
    logic [NREQ-1:0] r_req;
    logic            r_sync1;
    logic            r_sync2;
    logic            r_a;
    logic            r_b;
    logic [7:0]      r_cnt;
    logic [2:0]      r_grant;
    logic [NREQ-1:0] r_ack;
    logic [NREQ-1:0] r_res;
    logic            r_cel_a;
    logic            r_cel_b;
    logic            r_cel_rst;
    logic            r_err;

    logic [NREQ-1:0] w_gnt_oh;
    logic            w_gnt_req;
    logic            w_pick_valid;
    logic [2:0]      w_pick;
    logic            w_ld_ops;
    logic            w_drive;
    logic            w_done;
    logic            w_tmo;
    logic            w_settled;

    always_comb begin
        w_gnt_oh = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_gnt_oh[i] = (r_grant == 3'(i));
        end
        w_gnt_req = |(r_req & w_gnt_oh);
    end

    // Search from grant+1 upward; descending offsets so the nearest requester wins.
    always_comb begin
        int j;
        j            = 0;
        w_pick_valid = 1'b0;
        w_pick       = r_grant;
        for (int k = NREQ; k >= 1; k--) begin
            j = (int'(r_grant) + k) % NREQ;
            if (r_req[j]) begin
                w_pick_valid = 1'b1;
                w_pick       = j[2:0];
            end
        end
    end

    assign w_settled = (r_cnt >= L_SETTLE) && ((r_a != r_b) || (r_sync2 == r_a));

    always_comb begin
        w_nxt    = r_state;
        w_ld_ops = 1'b0;
        w_drive  = 1'b0;
        w_done   = 1'b0;
        w_tmo    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_pick_valid) w_nxt = S_ARB;
            end
            S_ARB: begin
                if (!w_gnt_req) begin
                    w_nxt = S_RELEASE;
                end else begin
                    w_nxt    = S_DRIVE;
                    w_ld_ops = 1'b1;
                end
            end
            S_DRIVE: begin
                if (!w_gnt_req) begin
                    w_nxt = S_RELEASE;
                end else begin
                    w_nxt   = S_WAIT;
                    w_drive = 1'b1;
                end
            end
            S_WAIT: begin
                if (!w_gnt_req) begin
                    w_nxt = S_RELEASE;
                end else if (w_settled) begin
                    w_nxt  = S_ACK;
                    w_done = 1'b1;
                end else if (r_cnt == L_TIMEOUT) begin
                    w_nxt  = S_ACK;
                    w_done = 1'b1;
                    w_tmo  = 1'b1;
                end
            end
            S_ACK: begin
                if (!w_gnt_req) w_nxt = S_RELEASE;
            end
            S_RELEASE: w_nxt = S_IDLE;
            default:   w_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state   <= S_IDLE;
            r_req     <= '0;
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_a       <= 1'b0;
            r_b       <= 1'b0;
            r_cnt     <= 8'd0;
            r_grant   <= 3'(NREQ - 1);
            r_ack     <= '0;
            r_res     <= '0;
            r_cel_a   <= 1'b0;
            r_cel_b   <= 1'b0;
            r_cel_rst <= 1'b1;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_nxt;
            r_req     <= req_i;
            r_sync1   <= cel_c_i;
            r_sync2   <= r_sync1;
            r_cel_rst <= 1'b0;
            if (r_state == S_IDLE && w_pick_valid) r_grant <= w_pick;
            if (w_ld_ops) begin
                r_a <= |(op_a_i & w_gnt_oh);
                r_b <= |(op_b_i & w_gnt_oh);
            end
            if (w_drive) begin
                r_cel_a <= r_a;
                r_cel_b <= r_b;
                r_cnt   <= 8'd0;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt + 8'd1;
            end
            if (w_done) begin
                r_ack <= w_gnt_oh;
                r_res <= w_gnt_oh & {NREQ{r_sync2}};
            end
            if (w_tmo) r_err <= 1'b1;
            if (r_state == S_RELEASE) begin
                r_ack <= '0;
                r_res <= '0;
            end
        end
    end

    assign ack_o       = r_ack;
    assign res_o       = r_res;
    assign cel_a_o     = r_cel_a;
    assign cel_b_o     = r_cel_b;
    assign cel_rst_o   = r_cel_rst;
    assign grant_o     = r_grant;
    assign busy_o      = (r_state != S_IDLE);
    assign err_o       = r_err;
    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_muller_c_sched.sv
// Directed-plus-random bench for muller_c_sched with a behavioural C-element and a
// transaction-level reference model (grant order, latency, result, error flag).
module tb_muller_c_sched;

    localparam int NREQ    = 4;
    localparam int SETTLE  = 3;
    localparam int TIMEOUT = 15;
    // Latencies counted in edges from the negedge where req is raised: one sampling edge, then the protocol.
    localparam int LAT_MIN = 1 + 3 + SETTLE + 1;
    localparam int LAT_TMO = 1 + 3 + TIMEOUT + 1;
    localparam int LAT_REL = 1 + 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] op_a;
    logic [NREQ-1:0] op_b;
    logic [NREQ-1:0] ack_o;
    logic [NREQ-1:0] res_o;
    logic            cel_a_o;
    logic            cel_b_o;
    logic            cel_rst_o;
    logic            c_env = 1'b0;
    logic [2:0]      grant_o;
    logic            busy_o;
    logic            err_o;
    logic [2:0]      dbg_state_o;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   last_grant;
    logic c_prev;
    logic last_a;
    logic last_b;
    logic stuck = 1'b0;
    logic err_m;

    muller_c_sched #(.NREQ(NREQ), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .req_i      (req),
        .op_a_i     (op_a),
        .op_b_i     (op_b),
        .ack_o      (ack_o),
        .res_o      (res_o),
        .cel_a_o    (cel_a_o),
        .cel_b_o    (cel_b_o),
        .cel_rst_o  (cel_rst_o),
        .cel_c_i    (c_env),
        .grant_o    (grant_o),
        .busy_o     (busy_o),
        .err_o      (err_o),
        .dbg_state_o(dbg_state_o)
    );

    always #5 clk = ~clk;

    // C-element with one cycle of delay; 'stuck' forces its output low.
    always @(posedge clk) begin
        if (cel_rst_o || stuck) c_env <= 1'b0;
        else if (cel_a_o == cel_b_o) c_env <= cel_a_o;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(input int last, input logic [NREQ-1:0] mask);
        for (int k = 1; k <= NREQ; k++) begin
            if (mask[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return last;
    endfunction

    task automatic wait_ack(output int lat);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (ack_o == '0 && lat < 40);
    endtask

    task automatic wait_ack_low(output int lat);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (ack_o != '0 && lat < 40);
    endtask

    task automatic txn(input int idx, input logic a, input logic b);
        int   lat;
        int   exp_lat;
        int   g;
        logic exp_res;
        g          = rr_pick(last_grant, NREQ'(1 << idx));
        last_grant = g;
        if (a != b) begin
            exp_lat = LAT_MIN;
            exp_res = c_prev;
        end else if (stuck && a) begin
            exp_lat = LAT_TMO;
            exp_res = 1'b0;
            err_m   = 1'b1;
        end else begin
            exp_lat = LAT_MIN;
            exp_res = a;
            c_prev  = a;
        end
        last_a = a;
        last_b = b;
        @(negedge clk);
        op_a[idx] = a;
        op_b[idx] = b;
        req[idx]  = 1'b1;
        wait_ack(lat);
        check("ack_latency", lat, exp_lat);
        check("ack_vec", 32'(ack_o), 32'(1) << g);
        check("grant", 32'(grant_o), g);
        check("res", 32'(res_o), 32'(exp_res) << g);
        check("err", 32'(err_o), 32'(err_m));
        check("cel_a", 32'(cel_a_o), 32'(a));
        check("cel_b", 32'(cel_b_o), 32'(b));
        check("busy_in_ack", 32'(busy_o), 1);
        @(negedge clk);
        req[idx] = 1'b0;
        wait_ack_low(lat);
        check("release_latency", lat, LAT_REL);
        check("busy_after_release", 32'(busy_o), 0);
        check("res_cleared", 32'(res_o), 0);
    endtask

    initial begin
        int lat;
        int g;
        int idx;
        logic ra;
        logic rb;

        // Reset with every requester already asking.
        rst  = 1'b1;
        req  = '1;
        op_a = '0;
        op_b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ack", 32'(ack_o), 0);
        check("rst_res", 32'(res_o), 0);
        check("rst_cel_a", 32'(cel_a_o), 0);
        check("rst_cel_b", 32'(cel_b_o), 0);
        check("rst_cel_rst", 32'(cel_rst_o), 1);
        check("rst_grant", 32'(grant_o), NREQ - 1);
        check("rst_busy", 32'(busy_o), 0);
        check("rst_err", 32'(err_o), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("cel_rst_release", 32'(cel_rst_o), 0);
        last_grant = NREQ - 1;
        g = rr_pick(last_grant, '1);
        last_grant = g;
        wait_ack(lat);
        check("first_grant_ack", 32'(ack_o), 32'(1) << g);
        check("first_grant", 32'(grant_o), g);
        @(negedge clk);
        req = '0;
        wait_ack_low(lat);
        check("first_release", lat, LAT_REL);
        c_prev = 1'b0;
        last_a = 1'b0;
        last_b = 1'b0;
        err_m  = 1'b0;

        // Switch, then hold against the switched value.
        txn(0, 1'b1, 1'b1);
        txn(2, 1'b0, 1'b1);
        check("hold_c_unchanged", 32'(c_env), 1);

        // Random single-requester traffic.
        for (int n = 0; n < 10; n++) begin
            idx = $urandom_range(0, NREQ - 1);
            ra  = 1'($urandom_range(0, 1));
            rb  = 1'($urandom_range(0, 1));
            txn(idx, ra, rb);
        end

        // Stuck C-element: timeout, sticky error.
        @(negedge clk);
        stuck  = 1'b1;
        c_prev = 1'b0;
        repeat (2) @(negedge clk);
        txn(1, 1'b1, 1'b1);
        @(negedge clk);
        stuck  = 1'b0;
        c_prev = (last_a == last_b) ? last_a : 1'b0;
        repeat (2) @(negedge clk);
        for (int n = 0; n < 3; n++) begin
            idx = $urandom_range(0, NREQ - 1);
            ra  = 1'($urandom_range(0, 1));
            rb  = 1'($urandom_range(0, 1));
            txn(idx, ra, rb);
        end
        check("err_sticky", 32'(err_o), 1);

        // Withdrawal during WAIT.
        ra = 1'($urandom_range(0, 1));
        rb = 1'($urandom_range(0, 1));
        last_grant = rr_pick(last_grant, NREQ'(1 << 3));
        if (ra == rb) c_prev = ra;
        last_a = ra;
        last_b = rb;
        @(negedge clk);
        op_a[3] = ra;
        op_b[3] = rb;
        req[3]  = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            check("wd_no_ack_before", 32'(ack_o), 0);
        end
        @(negedge clk);
        req[3] = 1'b0;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            check("wd_no_ack_after", 32'(ack_o), 0);
        end while (busy_o && lat < 20);
        check("wd_busy_fall", lat, LAT_REL);
        check("wd_grant", 32'(grant_o), 3);
        check("wd_err", 32'(err_o), 32'(err_m));

        // Fairness with everyone requesting.
        @(negedge clk);
        op_a = '0;
        op_b = '0;
        req  = '1;
        for (int n = 0; n < 5; n++) begin
            g = rr_pick(last_grant, '1);
            last_grant = g;
            wait_ack(lat);
            check("rr_ack", 32'(ack_o), 32'(1) << g);
            check("rr_grant", 32'(grant_o), g);
            @(negedge clk);
            if (n == 4) req = '0;
            else req[g] = 1'b0;
            wait_ack_low(lat);
            check("rr_release", lat, LAT_REL);
            if (n < 4) begin
                @(negedge clk);
                req[g] = 1'b1;
            end
        end
        c_prev = 1'b0;
        last_a = 1'b0;
        last_b = 1'b0;

        // Reset while an ack is held.
        @(negedge clk);
        op_a[1] = 1'b1;
        op_b[1] = 1'b1;
        req[1]  = 1'b1;
        g = rr_pick(last_grant, NREQ'(1 << 1));
        wait_ack(lat);
        check("mr_ack_before", 32'(ack_o), 32'(1) << g);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mr_ack", 32'(ack_o), 0);
        check("mr_res", 32'(res_o), 0);
        check("mr_cel_rst", 32'(cel_rst_o), 1);
        check("mr_grant", 32'(grant_o), NREQ - 1);
        check("mr_busy", 32'(busy_o), 0);
        check("mr_err", 32'(err_o), 0);
        check("mr_cel_a", 32'(cel_a_o), 0);
        @(negedge clk);
        req = '0;
        rst = 1'b0;
        @(posedge clk); #1;
        check("mr_cel_rst_release", 32'(cel_rst_o), 0);
        last_grant = NREQ - 1;
        err_m  = 1'b0;
        c_prev = 1'b0;
        last_a = 1'b0;
        last_b = 1'b0;
        txn(2, 1'b1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
